// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue: opcode values, the
// register-writing decode and the control FSM state encoding.
package wb_pkg;

  localparam int OPCD_W = 5;

  localparam logic [OPCD_W-1:0] OP_LW   = 5'd0;
  localparam logic [OPCD_W-1:0] OP_SW   = 5'd1;
  localparam logic [OPCD_W-1:0] OP_ADD  = 5'd2;
  localparam logic [OPCD_W-1:0] OP_SUB  = 5'd3;
  localparam logic [OPCD_W-1:0] OP_MUL  = 5'd4;
  localparam logic [OPCD_W-1:0] OP_DIV  = 5'd5;
  localparam logic [OPCD_W-1:0] OP_AND  = 5'd6;
  localparam logic [OPCD_W-1:0] OP_OR   = 5'd7;
  localparam logic [OPCD_W-1:0] OP_CMP  = 5'd8;
  localparam logic [OPCD_W-1:0] OP_NOT  = 5'd9;
  localparam logic [OPCD_W-1:0] OP_JR   = 5'd10;
  localparam logic [OPCD_W-1:0] OP_JPC  = 5'd11;
  localparam logic [OPCD_W-1:0] OP_BRLF = 5'd12;
  localparam logic [OPCD_W-1:0] OP_CALL = 5'd13;
  localparam logic [OPCD_W-1:0] OP_RET  = 5'd14;
  localparam logic [OPCD_W-1:0] OP_NOP  = 5'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_e;

  // True for opcodes whose result lands in the register file (CALL writes the link register)
  function automatic logic is_writing(input logic [OPCD_W-1:0] opcd);
    case (opcd)
      OP_LW, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_NOT, OP_CALL: is_writing = 1'b1;
      default:                        is_writing = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular result FIFO. Besides the head it presents every stored entry
// in age order (index 0 = oldest) with a valid mask, so the parent can
// search pending results for forwarding.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                         CLOCK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [W-1:0]                 push_entry,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count,
  output logic [DEPTH-1:0][W-1:0]      entries,
  output logic [DEPTH-1:0]             valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through the valid mask
  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

  // Age-ordered view of the storage for the forwarding search
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [PW-1:0] slot_idx;
    assign slot_idx    = rd_ptr_reg + PW'(gi);
    assign entries[gi] = mem[slot_idx];
    assign valid[gi]   = (CW'(gi) < count_reg);
  end

endmodule

// File: rtl/writeback_queue.sv
// Write-back stage: paces accepted instructions by a programmable slot
// length, queues register-file writes so a busy port stalls instead of
// dropping results, and lets decode forward still-pending results.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 4,
  parameter int SLOT_CYCLES = 6,
  parameter int LINK_REG    = 31,
  parameter int ZERO_RO     = 1
) (
  input  logic                     CLOCK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [OPCD_W-1:0]        OPCD_IN,
  input  logic [ADDR_W-1:0]        ADDR_REG_IN,
  input  logic [DATA_W-1:0]        DATA_IN,
  input  logic                     OPT_BIT_IN,
  output logic                     COND,
  output logic [ADDR_W-1:0]        ADDR_REG_OUT,
  output logic [DATA_W-1:0]        DATA_OUT,
  input  logic                     RF_READY,
  input  logic [ADDR_W-1:0]        FWD_ADDR,
  output logic                     FWD_HIT,
  output logic [DATA_W-1:0]        FWD_DATA,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     RETIRED
);

  localparam int ENT_W  = DATA_W + ADDR_W;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

  wb_state_e              state_reg;
  logic [SLOT_W-1:0]      slot_reg;
  logic                   retired_reg;

  logic                   accept;
  logic [ADDR_W-1:0]      dest_addr;
  logic                   wr_en;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [ENT_W-1:0]       head_entry;
  logic [DEPTH-1:0][ENT_W-1:0] view_entries;
  logic [DEPTH-1:0]       view_valid;

  // Readiness comes only from registered state, never from IN_VALID or RF_READY
  assign IN_READY = (state_reg == ST_RUN) && (slot_reg == '0) && !fifo_full;
  assign accept   = IN_VALID && IN_READY;
  assign RETIRED  = retired_reg;

  assign dest_addr = (OPCD_IN == OP_CALL) ? ADDR_W'(LINK_REG) : ADDR_REG_IN;
  assign wr_en     = accept && !OPT_BIT_IN && is_writing(OPCD_IN)
                     && !((ZERO_RO != 0) && (dest_addr == '0));

  // Control FSM: leave IDLE after reset, pace accepts with the slot counter, pulse RETIRED
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      slot_reg    <= '0;
      retired_reg <= 1'b0;
    end else begin
      retired_reg <= accept;
      case (state_reg)
        ST_IDLE: state_reg <= ST_RUN;
        ST_RUN: begin
          if (slot_reg != '0)
            slot_reg <= (slot_reg == SLOT_LAST) ? '0 : slot_reg + SLOT_W'(1);
          else if (accept && (SLOT_CYCLES > 1))
            slot_reg <= SLOT_W'(1);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  wb_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK      (CLOCK),
    .RST        (RST),
    .push       (wr_en),
    .push_entry ({DATA_IN, dest_addr}),
    .pop        (COND && RF_READY),
    .head       (head_entry),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (COUNT),
    .entries    (view_entries),
    .valid      (view_valid)
  );

  assign COND         = !fifo_empty;
  assign ADDR_REG_OUT = head_entry[ADDR_W-1:0];
  assign DATA_OUT     = head_entry[ENT_W-1:ADDR_W];

  // Forwarding search from oldest to youngest so the youngest match wins
  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_DATA = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (view_valid[k] && (view_entries[k][ADDR_W-1:0] == FWD_ADDR)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = view_entries[k][ENT_W-1:ADDR_W];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: two instances (slot length 6 and 1) share
// one stimulus stream and are compared every cycle with a list-based model.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  opcd;
  logic [4:0]  addr;
  logic [15:0] data;
  logic        opt_bit;
  logic        rf_ready;
  logic [4:0]  fwd_addr;

  logic [1:0]  o_ready;
  logic [1:0]  o_cond;
  logic [1:0]  o_fhit;
  logic [1:0]  o_ret;
  logic [4:0]  o_addr  [2];
  logic [15:0] o_data  [2];
  logic [15:0] o_fdata [2];
  logic [2:0]  o_count [2];

  int total = 0;
  int bad   = 0;

  // model state per instance: list index 0 is the oldest pending write
  ent_t m_list [2][DEPTH];
  int   m_cnt  [2];
  int   m_wait [2];
  bit   m_run  [2];
  bit   m_ret  [2];
  bit   last_acc [2];
  int   ret_seen;

  writeback_queue #(.SLOT_CYCLES(6)) u_a (
    .CLOCK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(o_ready[0]),
    .OPCD_IN(opcd), .ADDR_REG_IN(addr), .DATA_IN(data), .OPT_BIT_IN(opt_bit),
    .COND(o_cond[0]), .ADDR_REG_OUT(o_addr[0]), .DATA_OUT(o_data[0]),
    .RF_READY(rf_ready), .FWD_ADDR(fwd_addr), .FWD_HIT(o_fhit[0]),
    .FWD_DATA(o_fdata[0]), .COUNT(o_count[0]), .RETIRED(o_ret[0])
  );

  writeback_queue #(.SLOT_CYCLES(1)) u_b (
    .CLOCK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(o_ready[1]),
    .OPCD_IN(opcd), .ADDR_REG_IN(addr), .DATA_IN(data), .OPT_BIT_IN(opt_bit),
    .COND(o_cond[1]), .ADDR_REG_OUT(o_addr[1]), .DATA_OUT(o_data[1]),
    .RF_READY(rf_ready), .FWD_ADDR(fwd_addr), .FWD_HIT(o_fhit[1]),
    .FWD_DATA(o_fdata[1]), .COUNT(o_count[1]), .RETIRED(o_ret[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_len(input int k);
    return (k == 0) ? 6 : 1;
  endfunction

  function automatic bit writes(input logic [4:0] op);
    return op inside {5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd13};
  endfunction

  function automatic bit m_ready(input int k);
    return m_run[k] && (m_wait[k] == 0) && (m_cnt[k] < DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wait[k] = 0;
      m_run[k]  = 0;
      m_ret[k]  = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      ent_t        h;
      bit          fh;
      logic [15:0] fd;
      h  = (m_cnt[k] > 0) ? m_list[k][0] : '0;
      fh = 0;
      fd = '0;
      for (int i = 0; i < m_cnt[k]; i++)
        if (m_list[k][i].a == fwd_addr) begin
          fh = 1;
          fd = m_list[k][i].d;
        end
      check($sformatf("in_ready[%0d]", k), 32'(o_ready[k]), 32'(m_ready(k)));
      check($sformatf("cond[%0d]", k),     32'(o_cond[k]),  32'(m_cnt[k] > 0));
      check($sformatf("addr_out[%0d]", k), 32'(o_addr[k]),  32'(h.a));
      check($sformatf("data_out[%0d]", k), 32'(o_data[k]),  32'(h.d));
      check($sformatf("count[%0d]", k),    32'(o_count[k]), 32'(m_cnt[k]));
      check($sformatf("retired[%0d]", k),  32'(o_ret[k]),   32'(m_ret[k]));
      check($sformatf("fwd_hit[%0d]", k),  32'(o_fhit[k]),  32'(fh));
      check($sformatf("fwd_data[%0d]", k), 32'(o_fdata[k]), 32'(fd));
    end
  endtask

  // one clock: predict from current inputs, advance the model, compare after the edge
  task automatic step();
    bit   acc [2];
    bit   pop [2];
    bit   wr;
    ent_t e;
    e.a = (opcd == 5'd13) ? 5'd31 : addr;
    e.d = data;
    wr  = !opt_bit && writes(opcd) && (e.a != 5'd0);
    for (int k = 0; k < 2; k++) begin
      acc[k] = in_valid && m_ready(k);
      pop[k] = (m_cnt[k] > 0) && rf_ready;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (pop[k]) begin
        for (int i = 0; i < DEPTH - 1; i++) m_list[k][i] = m_list[k][i+1];
        m_cnt[k]--;
      end
      if (acc[k] && wr) begin
        m_list[k][m_cnt[k]] = e;
        m_cnt[k]++;
      end
      if (acc[k] && slot_len(k) > 1) m_wait[k] = slot_len(k) - 1;
      else if (m_wait[k] > 0)        m_wait[k]--;
      m_ret[k]    = acc[k];
      m_run[k]    = 1;
      last_acc[k] = acc[k];
    end
    if (o_ret[0]) ret_seen++;
    compare_all();
  endtask

  // hold an instruction valid until instance k takes it (bounded)
  task automatic offer(input logic [4:0] op, input logic [4:0] ra, input logic [15:0] d,
                       input logic ob, input int k, input int max_steps);
    bit got;
    opcd = op; addr = ra; data = d; opt_bit = ob; in_valid = 1'b1;
    got = 0;
    for (int n = 0; n < max_steps && !got; n++) begin
      step();
      got = last_acc[k];
    end
    check($sformatf("accepted_op%0d_inst%0d", op, k), 32'(got), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; opcd = 0; addr = 0; data = 0; opt_bit = 0;
    rf_ready = 0; fwd_addr = 0; ret_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    compare_all();

    // 1: reset release and first accept on the slot-6 instance
    step();
    check("ready_after_release", 32'(o_ready[0]), 32'(1));
    opcd = 5'd2; addr = 5'd3; data = 16'h1234; opt_bit = 0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("add_cond",  32'(o_cond[0]), 32'(1));
    check("add_addr",  32'(o_addr[0]), 32'(3));
    check("add_data",  32'(o_data[0]), 32'h1234);
    check("slot_busy0", 32'(o_ready[0]), 32'(0));
    for (int i = 1; i < 5; i++) begin
      step();
      check($sformatf("slot_busy%0d", i), 32'(o_ready[0]), 32'(0));
    end
    step();
    check("slot_free", 32'(o_ready[0]), 32'(1));
    rf_ready = 1'b1;
    idle_steps(6);

    // 2: instructions that consume a slot without writing
    ret_seen = 0;
    offer(5'd1,  5'd4, 16'h1111, 1'b0, 0, 10);
    offer(5'd8,  5'd4, 16'h2222, 1'b0, 0, 10);
    offer(5'd15, 5'd4, 16'h3333, 1'b0, 0, 10);
    offer(5'd2,  5'd4, 16'h4444, 1'b1, 0, 10);
    offer(5'd2,  5'd0, 16'h5555, 1'b0, 0, 10);
    check("nonwrite_retired", 32'(ret_seen), 32'(5));
    check("nonwrite_count",   32'(o_count[0]), 32'(0));
    idle_steps(6);

    // 3: back-pressure on the slot-1 instance
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) offer(5'd0, 5'(i), 16'(16'h0100 + i), 1'b0, 1, 4);
    opcd = 5'd0; addr = 5'd5; data = 16'h0105; opt_bit = 0; in_valid = 1'b1;
    step(); step(); step();
    check("bp_count", 32'(o_count[1]), 32'(4));
    check("bp_ready", 32'(o_ready[1]), 32'(0));
    check("bp_head",  32'(o_addr[1]),  32'(1));
    rf_ready = 1'b1;
    step();
    check("drain1_head",  32'(o_addr[1]),  32'(2));
    check("drain1_count", 32'(o_count[1]), 32'(3));
    check("drain1_ready", 32'(o_ready[1]), 32'(1));
    step();
    in_valid = 1'b0;
    check("drain2_count", 32'(o_count[1]), 32'(3));
    check("drain2_head",  32'(o_addr[1]),  32'(3));
    idle_steps(6);

    // 4: forwarding picks the youngest pending result
    rf_ready = 1'b0;
    offer(5'd2, 5'd7, 16'h0001, 1'b0, 0, 10);
    offer(5'd3, 5'd7, 16'h00FF, 1'b0, 0, 10);
    fwd_addr = 5'd7;
    step();
    check("fwd7_hit",  32'(o_fhit[0]),  32'(1));
    check("fwd7_data", 32'(o_fdata[0]), 32'h00FF);
    fwd_addr = 5'd8;
    step();
    check("fwd8_hit",  32'(o_fhit[0]),  32'(0));
    check("fwd8_data", 32'(o_fdata[0]), 32'(0));
    rf_ready = 1'b1;
    idle_steps(8);

    // 5: CALL writes the link register
    rf_ready = 1'b0;
    offer(5'd13, 5'd5, 16'h0042, 1'b0, 0, 10);
    check("call_addr", 32'(o_addr[0]), 32'(31));
    check("call_data", 32'(o_data[0]), 32'h0042);
    rf_ready = 1'b1;
    idle_steps(8);

    // random traffic against the model
    for (int n = 0; n < 250; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      opcd     = 5'($urandom_range(0, 31));
      addr     = 5'($urandom_range(0, 7));
      data     = 16'($urandom);
      opt_bit  = ($urandom_range(0, 7) == 0);
      rf_ready = ($urandom_range(0, 2) != 0);
      fwd_addr = 5'($urandom_range(0, 7));
      step();
    end

    // 6: asynchronous reset while three writes are pending
    rf_ready = 1'b1;
    idle_steps(8);
    rf_ready = 1'b0;
    offer(5'd2, 5'd1, 16'hA001, 1'b0, 0, 10);
    offer(5'd2, 5'd2, 16'hA002, 1'b0, 0, 10);
    offer(5'd2, 5'd3, 16'hA003, 1'b0, 0, 10);
    check("pre_reset_count", 32'(o_count[0]), 32'(3));
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_cond[%0d]", k),  32'(o_cond[k]),  32'(0));
      check($sformatf("async_count[%0d]", k), 32'(o_count[k]), 32'(0));
      check($sformatf("async_ready[%0d]", k), 32'(o_ready[k]), 32'(0));
    end
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_reset_cond%0d", i), 32'(o_cond[0]), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
